// File: rtl/ram_responder.sv
// Single-port word RAM slave with a fixed BUSY latency and a FREE/BUSY/ACCESS/ERROR handshake.
// Optional RAM_ADDR_CHECK_EN: out-of-range word indices raise ERROR instead of wrapping modulo DEPTH.
package ram_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// state  | meaning
// FREE   | idle, no request pending
// BUSY   | request latched, counting down the access latency
// ACCESS | one-cycle completion: read data valid / write committed
// ERROR  | one-cycle flag for REN&WEN conflict or out-of-range address
module ram_responder
  import ram_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_C = 4'(LAT);

  logic [31:0] mem [DEPTH];

  ramstate_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] load_q, load_d;

  logic          req, conflict, changed, oor, start;
  logic          acc_go, acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;

  assign req      = ramREN ^ ramWEN;
  assign conflict = ramREN & ramWEN;
  assign changed  = (ramaddr != addr_q) || (ramREN != ren_q) || (ramWEN != wen_q);

`ifdef RAM_ADDR_CHECK_EN
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  assign oor = (ramaddr[31:2] >= DEPTH_W);
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    data_d   = data_q;
    load_d   = load_q;
    start    = 1'b0;
    acc_go   = 1'b0;
    acc_we   = wen_q;
    acc_idx  = addr_q[AW+1:2];
    acc_data = data_q;

    if (conflict) begin
      state_d = ERROR;
    end else begin
      unique case (state_q)
        BUSY: begin
          if (!req) begin
            state_d = FREE;
          end else if (changed) begin
            start = 1'b1;
          end else if (cnt_q <= 4'd1) begin
            state_d = ACCESS;
            acc_go  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          if (req) start = 1'b1;
          else     state_d = FREE;
        end
      endcase

      if (start) begin
        ren_d  = ramREN;
        wen_d  = ramWEN;
        addr_d = ramaddr;
        data_d = ramstore;
        cnt_d  = LAT_C;
        if (oor) begin
          state_d = ERROR;
        end else if (LAT == 0) begin
          // Zero latency completes on the accepting edge, so use the live request.
          state_d  = ACCESS;
          acc_go   = 1'b1;
          acc_we   = ramWEN;
          acc_idx  = ramaddr[AW+1:2];
          acc_data = ramstore;
        end else begin
          state_d = BUSY;
        end
      end
    end

    if (acc_go && !acc_we) load_d = mem[acc_idx];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

  // The array has no reset; contents survive RST.
  always_ff @(posedge CLK) begin
    if (!RST && acc_go && acc_we) mem[acc_idx] <= acc_data;
  end

  assign ramstate = state_q;
  assign ramload  = load_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder: transaction-level timing/data model with a shadow memory.
module tb_ram_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ramREN = 1'b0;
  logic        ramWEN = 1'b0;
  logic [31:0] ramaddr = '0;
  logic [31:0] ramstore = '0;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_load = '0;
  int          pool [8] = '{0, 4, 16, 32, 64, 128, 5, 1023};

  ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'({2'b00, a[31:2]} % 32'(DEPTH));
  endfunction

  task automatic idle(input int n);
    ramREN = 1'b0;
    ramWEN = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      check("idle_state", 32'(ramstate), 32'(S_FREE));
      check("idle_load", ramload, exp_load);
    end
  endtask

  // Full transaction: request held LAT BUSY cycles, one ACCESS, then released to FREE.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data, input string tag);
    int i;
    i = widx(addr);
    ramREN = !wr; ramWEN = wr; ramaddr = addr; ramstore = data;
    for (int k = 0; k < LAT; k++) begin
      @(negedge CLK);
      check({tag, "_busy"}, 32'(ramstate), 32'(S_BUSY));
      ramstore = $urandom;
    end
    @(negedge CLK);
    check({tag, "_access"}, 32'(ramstate), 32'(S_ACCESS));
    if (wr) model[i] = data;
    else    exp_load = model[i];
    check({tag, "_load"}, ramload, exp_load);
    ramREN = 1'b0; ramWEN = 1'b0;
    @(negedge CLK);
    check({tag, "_free"}, 32'(ramstate), 32'(S_FREE));
    check({tag, "_hold"}, ramload, exp_load);
  endtask

  task automatic conflict_pulse(input logic [31:0] addr);
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = addr; ramstore = $urandom;
    @(negedge CLK);
    check("conf_err", 32'(ramstate), 32'(S_ERROR));
    check("conf_load", ramload, exp_load);
    ramREN = 1'b0; ramWEN = 1'b0;
    @(negedge CLK);
    check("conf_free", 32'(ramstate), 32'(S_FREE));
  endtask

  initial begin
    logic [31:0] a;
    int p, al;

    ramREN = 1'b1; ramaddr = 32'h40;
    repeat (3) @(negedge CLK);
    check("rst_state", 32'(ramstate), 32'(S_FREE));
    check("rst_load", ramload, 32'h0);
    exp_load = '0;
    RST = 1'b0;
    idle(2);

    foreach (pool[j]) xfer(1'b1, 32'(pool[j]) << 2, $urandom, "pre");

    xfer(1'b1, 32'h40, 32'hDEADBEEF, "wr40");
    xfer(1'b0, 32'h40, 32'h0, "rd40");

    // Address switch after one BUSY cycle restarts the latency count.
    ramREN = 1'b1; ramaddr = 32'h100;
    @(negedge CLK);
    check("sw_busy0", 32'(ramstate), 32'(S_BUSY));
    ramaddr = 32'h200;
    @(negedge CLK); check("sw_busy1", 32'(ramstate), 32'(S_BUSY));
    @(negedge CLK); check("sw_busy2", 32'(ramstate), 32'(S_BUSY));
    @(negedge CLK); check("sw_access", 32'(ramstate), 32'(S_ACCESS));
    exp_load = model[widx(32'h200)];
    check("sw_load", ramload, exp_load);
    idle(1);

    // Abort: write dropped in BUSY must not commit.
    ramWEN = 1'b1; ramaddr = 32'h80; ramstore = 32'h1234;
    @(negedge CLK); check("ab_busy", 32'(ramstate), 32'(S_BUSY));
    idle(2);
    xfer(1'b0, 32'h80, 32'h0, "ab_rd");

    conflict_pulse(32'h40);
    xfer(1'b0, 32'h40, 32'h0, "conf_rd");

    // Conflict arising mid-BUSY.
    ramREN = 1'b1; ramaddr = 32'h100;
    @(negedge CLK); check("cb_busy", 32'(ramstate), 32'(S_BUSY));
    ramWEN = 1'b1; ramstore = $urandom;
    @(negedge CLK); check("cb_err", 32'(ramstate), 32'(S_ERROR));
    idle(1);
    xfer(1'b0, 32'h100, 32'h0, "cb_rd");

    // Back-to-back: request held through ACCESS is re-accepted with the new address.
    ramREN = 1'b1; ramaddr = 32'h40;
    @(negedge CLK); check("bb_b0", 32'(ramstate), 32'(S_BUSY));
    @(negedge CLK); check("bb_b1", 32'(ramstate), 32'(S_BUSY));
    @(negedge CLK); check("bb_a0", 32'(ramstate), 32'(S_ACCESS));
    exp_load = model[widx(32'h40)];
    check("bb_l0", ramload, exp_load);
    ramaddr = 32'h200;
    @(negedge CLK); check("bb_b2", 32'(ramstate), 32'(S_BUSY));
    @(negedge CLK); check("bb_b3", 32'(ramstate), 32'(S_BUSY));
    @(negedge CLK); check("bb_a1", 32'(ramstate), 32'(S_ACCESS));
    exp_load = model[widx(32'h200)];
    check("bb_l1", ramload, exp_load);
    idle(1);

    // Reset during BUSY of a write.
    ramWEN = 1'b1; ramaddr = 32'h10; ramstore = 32'hA5A5A5A5;
    @(negedge CLK); check("rm_busy", 32'(ramstate), 32'(S_BUSY));
    RST = 1'b1; ramWEN = 1'b0;
    @(negedge CLK);
    check("rm_state", 32'(ramstate), 32'(S_FREE));
    check("rm_load", ramload, 32'h0);
    exp_load = '0;
    RST = 1'b0;
    idle(1);
    xfer(1'b0, 32'h10, 32'h0, "rm_rd");

`ifdef RAM_ADDR_CHECK_EN
    ramREN = 1'b1; ramaddr = 32'h1000;
    @(negedge CLK); check("rng_err", 32'(ramstate), 32'(S_ERROR));
    check("rng_load", ramload, exp_load);
    idle(1);
`else
    xfer(1'b0, 32'h1000, 32'h0, "rng_wrap");
`endif

    for (int n = 0; n < 60; n++) begin
      p = $urandom_range(0, 7);
`ifdef RAM_ADDR_CHECK_EN
      al = 0;
`else
      al = $urandom_range(0, 3);
`endif
      a = 32'(pool[p] + DEPTH * al);
      a = (a << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) conflict_pulse(a);
      else xfer(1'($urandom_range(0, 1)), a, $urandom, "rnd");
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning BUSY cycles per access (legal range 0..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words in the array (power of two).
REQ-003 SHALL have port CLK  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port ramREN  in  1  read request, level, held by the initiator until ACCESS.
REQ-006 SHALL have port ramWEN  in  1  write request, level, held by the initiator until ACCESS.
REQ-007 SHALL have port ramaddr  in  32  byte address; bits [1:0] ignored; word index = ramaddr[31:2].
REQ-008 SHALL have port ramstore  in  32  write data.
REQ-009 SHALL have port ramload  out  32  read data, registered.
REQ-010 SHALL have port ramstate  out  2  ram_pkg ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-011 SHALL drive ramstate straight from a state register holding FREE, BUSY, ACCESS or ERROR.
REQ-012 SHALL treat a request as present when ramREN xor ramWEN is 1.
REQ-013 SHALL, in FREE or ACCESS with a request present at edge t, latch op/addr/data, load counter=LAT, and enter BUSY (LAT>0) or ACCESS (LAT=0) at t+1.
REQ-014 SHALL decrement the counter in BUSY each cycle and enter ACCESS on the edge where the counter is 1, giving ACCESS exactly LAT+1 cycles after acceptance.
REQ-015 SHALL, on entering ACCESS for a read, register ramload = mem[latched index] so it is valid throughout the ACCESS cycle.
REQ-016 SHALL commit a write mem[latched index] = latched data on the edge that enters ACCESS; ramload SHALL hold its previous value.
REQ-017 SHALL hold ACCESS for one cycle only, then go to BUSY/ACCESS per REQ-013 if a request is present, else FREE.
REQ-018 SHALL return to FREE on the next edge when the request drops during BUSY (abort), with no write committed.
REQ-019 SHALL restart (reload counter=LAT, relatch op/addr/data, stay BUSY) when ramaddr, ramREN or ramWEN differs from the latched values during BUSY.
REQ-020 SHALL enter ERROR for one cycle when ramREN and ramWEN are both 1 at any edge outside RST, with no memory write, then follow REQ-017 rules.
REQ-021 SHALL keep ramstate FREE and ramload unchanged while no request is present.
REQ-022 SHALL satisfy read-after-write: a read accepted after a write's ACCESS returns the written data.

Reset
REQ-023 SHALL, while RST=1 at an edge, set ramstate=FREE, ramload=32'h0 and counter=0, overriding any request.
REQ-024 SHALL abort an in-flight access on reset without committing its write.
REQ-025 SHALL NOT clear the memory array on reset.

Configuration
REQ-026 SHALL use macro RAM_ADDR_CHECK_EN: when defined, a request with ramaddr[31:2] >= DEPTH enters ERROR for one cycle instead of BUSY, with no memory access.
REQ-027 SHALL, when RAM_ADDR_CHECK_EN is undefined, wrap the word index modulo DEPTH and never flag out-of-range addresses.

Verification
REQ-028 SHALL cover write then read: write 0x0000_0040 <- 0xDEADBEEF, LAT=2 -> BUSY 2 cycles, ACCESS; read 0x40 -> ACCESS on cycle 3 after acceptance, ramload=0xDEADBEEF.
REQ-029 SHALL cover address switch: read 0x100, change to 0x200 after 1 BUSY cycle -> counter restarts, ACCESS 3 cycles after the switch, ramload=mem[0x200].
REQ-030 SHALL cover abort: write 0x80 <- 0x1234, drop ramWEN in BUSY -> FREE next cycle; later read 0x80 returns the old value.
REQ-031 SHALL cover conflict: ramREN=ramWEN=1 -> ERROR one cycle, memory unchanged.
REQ-032 SHALL cover reset mid-access: RST during BUSY of write 0x10 <- 0xA5A5A5A5 -> FREE, ramload=0, 0x10 unchanged.
REQ-033 SHALL cover range: read 0x0000_1000 with DEPTH=1024 -> ERROR with RAM_ADDR_CHECK_EN; ramload=mem[0] without it.
